// File: rtl/dense_weight_streamer.sv
// Streams a DEPTH-word weight table from a registered-read ROM through a 2-entry skid buffer.
// Optional multi-pass streaming (input loops) is enabled by defining DENSE_STREAM_LOOP_EN.
module dense_weight_streamer #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
`ifdef DENSE_STREAM_LOOP_EN
    input  logic [3:0]        loops,
`endif
    output logic [ADDR_W-1:0] readAddr,
    input  logic [DATA_W-1:0] romData,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH does not fit in ADDR_W address bits");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    // Handshake: a word transfers on every cycle with out_valid=1 and out_ready=1;
    // once out_valid rises, out_data/out_last hold until that transfer.
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_last_q, rd_last_d;
    logic [DATA_W-1:0]   buf_data_q [2];
    logic [DATA_W-1:0]   buf_data_d [2];
    logic [1:0]          buf_last_q, buf_last_d;
    logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                final_pass;
`ifdef DENSE_STREAM_LOOP_EN
    logic [3:0]          pass_q, pass_d;
    assign final_pass = (pass_q == 4'd0);
`else
    assign final_pass = 1'b1;
`endif

    logic              accept, issue, at_end, hs, push, pop;
    logic              head_valid, head_last;
    logic [DATA_W-1:0] head_data;
    logic [1:0]        occ;

    // The word returning from the ROM is presented directly when the buffer is empty.
    assign head_valid = (cnt_q != 2'd0) || rd_pend_q;
    assign head_data  = (cnt_q != 2'd0) ? buf_data_q[rd_ptr_q] : romData;
    assign head_last  = (cnt_q != 2'd0) ? buf_last_q[rd_ptr_q] : rd_last_q;
    assign hs         = head_valid && out_ready;
    assign push       = rd_pend_q && !(hs && (cnt_q == 2'd0));
    assign pop        = hs && (cnt_q != 2'd0);
    assign occ        = cnt_q + {1'b0, rd_pend_q};
    assign accept     = (state_q == S_IDLE) && start && !done_q;
    assign issue      = (state_q == S_RUN) && (occ < 2'd2);
    assign at_end     = (addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            rd_pend_q     <= 1'b0;
            rd_last_q     <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q    <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
`ifdef DENSE_STREAM_LOOP_EN
            pass_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_pend_q  <= rd_pend_d;
            rd_last_q  <= rd_last_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
`ifdef DENSE_STREAM_LOOP_EN
            pass_q     <= pass_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (issue && at_end && final_pass) state_d = S_DRAIN;
            S_DRAIN: if (hs && head_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        rd_pend_d  = issue;
        rd_last_d  = issue && at_end && final_pass;
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        done_d     = (state_q == S_DRAIN) && hs && head_last;
`ifdef DENSE_STREAM_LOOP_EN
        pass_d     = pass_q;
        if (accept)
            pass_d = loops;
        else if (issue && at_end && !final_pass)
            pass_d = pass_q - 4'd1;
`endif
        // The address only wraps between passes; after the final read it parks at DEPTH-1.
        if (accept) begin
            addr_d = '0;
        end else if (issue) begin
            if (!at_end)
                addr_d = addr_q + ADDR_W'(1);
            else if (!final_pass)
                addr_d = '0;
        end
        if (push) begin
            buf_data_d[wr_ptr_q] = romData;
            buf_last_d[wr_ptr_q] = rd_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        readAddr  = addr_q;
        out_valid = head_valid;
        out_data  = head_valid ? head_data : '0;
        out_last  = head_valid && head_last;
        busy      = (state_q != S_IDLE);
        done      = done_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_dense_weight_streamer.sv
// Directed bench for dense_weight_streamer with a behavioural registered-read table ROM.
module tb_dense_weight_streamer;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 20;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        loops = 4'd0;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int cyc0 = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              got_last_q[$];
  int                got_cyc_q[$];
  int                done_cyc_q[$];

  dense_weight_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
`ifdef DENSE_STREAM_LOOP_EN
    .loops(loops),
`endif
    .readAddr(read_addr),
    .romData(rom_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] rom_word(input int i);
    if (i == 127) return 20'h13430;
    return 20'h043d0 + DATA_W'(i * 485);
  endfunction

  always @(posedge clock) rom_data <= rom_word(int'(read_addr));

  // handshake and done monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
      got_cyc_q.push_back(cyc - cyc0);
    end
    if (done) done_cyc_q.push_back(cyc - cyc0);
  end

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (read_addr !== '0 || out_data !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0d data=%05h valid=%b last=%b busy=%b done=%b st=%0d, want all 0",
               read_addr, out_data, out_valid, out_last, busy, done, dbg_state);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_release: busy=%b valid=%b, want 0 0", busy, out_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int n_last;
    int last_idx;
    clear_sb();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom_word(i));
    for (int c = 0; c < 145; c++) begin
      if (c == 0) cyc0 = cyc;
      start = (c == 0);
      out_ready = 1'b1;
      @(negedge clock);
      if (c == 1) begin
        n_checks++;
        if (read_addr !== 7'd0 || busy !== 1'b1 || out_valid !== 1'b0 || dbg_state !== 2'd1) begin
          n_fail++;
          $display("FAIL basic_issue0: addr=%0d busy=%b valid=%b st=%0d, want 0 1 0 1",
                   read_addr, busy, out_valid, dbg_state);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 20'h043d0) begin
          n_fail++;
          $display("FAIL basic_first_word: valid=%b data=%05h, want 1 043d0", out_valid, out_data);
        end
      end
      if (c == 128) begin
        n_checks++;
        if (out_last !== 1'b0 || out_data !== rom_word(126)) begin
          n_fail++;
          $display("FAIL basic_word126: last=%b data=%05h, want 0 %05h", out_last, out_data, rom_word(126));
        end
      end
      if (c == 129) begin
        n_checks++;
        if (out_last !== 1'b1 || out_data !== 20'h13430 || dbg_state !== 2'd2) begin
          n_fail++;
          $display("FAIL basic_last_word: last=%b data=%05h st=%0d, want 1 13430 2", out_last, out_data, dbg_state);
        end
      end
      if (c == 130) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_done: done=%b busy=%b, want 1 0", done, busy);
        end
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    n_checks++;
    if (got_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL basic_count: got %0d words, want %0d", got_q.size(), DEPTH);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_order: word %0d got %05h, want %05h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        break;
      end
    end
    n_last = 0;
    last_idx = -1;
    foreach (got_last_q[i]) if (got_last_q[i]) begin n_last++; last_idx = i; end
    n_checks++;
    if (n_last != 1 || last_idx != 127 || got_cyc_q.size() < 128 || got_cyc_q[127] != 129) begin
      n_fail++;
      $display("FAIL basic_last_flag: count=%0d idx=%0d, want 1 at 127 cycle 129", n_last, last_idx);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 130) begin
      n_fail++;
      $display("FAIL basic_done_pulses: count=%0d, want one at cycle 130", done_cyc_q.size());
    end
  endtask

  task automatic test_alternating();
    int bad_gap;
    clear_sb();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom_word(i));
    for (int c = 0; c < 270; c++) begin
      if (c == 0) cyc0 = cyc;
      start = (c == 0);
      out_ready = (c % 2 == 0);
      @(negedge clock);
      @(posedge clock); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL alt_order: word %0d got %05h, want %05h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        break;
      end
    end
    bad_gap = 0;
    for (int i = 1; i < got_cyc_q.size(); i++) if (got_cyc_q[i] - got_cyc_q[i-1] != 2) bad_gap++;
    n_checks++;
    if (got_q.size() != DEPTH || bad_gap != 0 || got_cyc_q[0] != 2) begin
      n_fail++;
      $display("FAIL alt_rate: words=%0d bad_gaps=%0d, want 128 words every 2nd cycle from 2", got_q.size(), bad_gap);
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 257) begin
      n_fail++;
      $display("FAIL alt_done: count=%0d, want one at cycle 257", done_cyc_q.size());
    end
  endtask

  task automatic test_stall();
    clear_sb();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom_word(i));
    for (int c = 0; c < 160; c++) begin
      if (c == 0) cyc0 = cyc;
      start = (c == 0);
      out_ready = !(c >= 7 && c <= 16);
      @(negedge clock);
      if (c == 8 || c == 16) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== rom_word(5) || read_addr !== 7'd7) begin
          n_fail++;
          $display("FAIL stall_hold_c%0d: valid=%b data=%05h addr=%0d, want 1 %05h 7",
                   c, out_valid, out_data, read_addr, rom_word(5));
        end
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    n_checks++;
    if (got_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL stall_count: got %0d words, want %0d", got_q.size(), DEPTH);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_order: word %0d got %05h, want %05h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        break;
      end
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 140) begin
      n_fail++;
      $display("FAIL stall_done: count=%0d, want one at cycle 140", done_cyc_q.size());
    end
  endtask

  task automatic test_restart();
    clear_sb();
    for (int p = 0; p < 2; p++) for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom_word(i));
    for (int c = 0; c < 280; c++) begin
      if (c == 0) cyc0 = cyc;
      start = (c == 0 || c == 42 || c == 130 || c == 131);
      out_ready = 1'b1;
      @(negedge clock);
      if (c == 131) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL restart_on_done: busy=%b, want 0", busy);
        end
      end
      if (c == 132) begin
        n_checks++;
        if (busy !== 1'b1 || read_addr !== 7'd0) begin
          n_fail++;
          $display("FAIL restart_after_done: busy=%b addr=%0d, want 1 0", busy, read_addr);
        end
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    n_checks++;
    if (got_q.size() != 2 * DEPTH) begin
      n_fail++;
      $display("FAIL restart_count: got %0d words, want %0d", got_q.size(), 2 * DEPTH);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart_order: word %0d got %05h, want %05h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        break;
      end
    end
    n_checks++;
    if (done_cyc_q.size() != 2 || done_cyc_q[0] != 130 || done_cyc_q[1] != 261) begin
      n_fail++;
      $display("FAIL restart_done: count=%0d, want two at cycles 130 and 261", done_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_sb();
    for (int i = 0; i < 60; i++) exp_q.push_back(rom_word(i));
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom_word(i));
    for (int c = 0; c < 204; c++) begin
      if (c == 0) cyc0 = cyc;
      start = (c == 0 || c == 64);
      out_ready = 1'b1;
      if (c == 62) reset_n = 1'b0;
      if (c == 64) reset_n = 1'b1;
      @(negedge clock);
      if (c == 62) begin
        n_checks++;
        if (read_addr !== '0 || out_data !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_clear: addr=%0d data=%05h valid=%b last=%b busy=%b done=%b, want all 0",
                   read_addr, out_data, out_valid, out_last, busy, done);
        end
      end
      if (c == 64) begin
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_stale: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
      end
      if (c == 66) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== rom_word(0)) begin
          n_fail++;
          $display("FAIL midreset_restart: valid=%b data=%05h, want 1 %05h", out_valid, out_data, rom_word(0));
        end
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    n_checks++;
    if (got_q.size() != 60 + DEPTH) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d words, want %0d", got_q.size(), 60 + DEPTH);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_order: word %0d got %05h, want %05h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        break;
      end
    end
    n_checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != 194) begin
      n_fail++;
      $display("FAIL midreset_done: count=%0d, want one at cycle 194", done_cyc_q.size());
    end
  endtask

`ifdef DENSE_STREAM_LOOP_EN
  task automatic test_loops();
    int n_last;
    int last_idx;
    clear_sb();
    for (int p = 0; p < 3; p++) for (int i = 0; i < DEPTH; i++) exp_q.push_back(rom_word(i));
    for (int c = 0; c < 400; c++) begin
      if (c == 0) cyc0 = cyc;
      start = (c == 0);
      loops = (c == 0) ? 4'd2 : 4'd0;
      out_ready = 1'b1;
      @(negedge clock);
      @(posedge clock); #1;
    end
    start = 1'b0;
    n_checks++;
    if (got_q.size() != 3 * DEPTH || got_q[128] !== 20'h043d0 || got_cyc_q[383] != 385) begin
      n_fail++;
      $display("FAIL loops_shape: words=%0d word128=%05h, want 384 043d0 no bubbles", got_q.size(), got_q[128]);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL loops_order: word %0d got %05h, want %05h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
        break;
      end
    end
    n_last = 0;
    last_idx = -1;
    foreach (got_last_q[i]) if (got_last_q[i]) begin n_last++; last_idx = i; end
    n_checks++;
    if (n_last != 1 || last_idx != 383 || done_cyc_q.size() != 1 || done_cyc_q[0] != 386) begin
      n_fail++;
      $display("FAIL loops_last: last count=%0d idx=%0d done count=%0d, want 1 383 1", n_last, last_idx, done_cyc_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_alternating();
    test_stall();
    test_restart();
    test_reset_mid();
`ifdef DENSE_STREAM_LOOP_EN
    test_loops();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
